udp_tx_arbiter: RTL and testbench

- Shares the single UDP transmit path (request/ack/valid/data/length) among NUM_REQ packet sources, such as the command sender and status reporters.
- Selects requesters by round-robin and performs the request/ack handshake with the UDP stack.
- Streams each granted requester's bytes to the stack, counting them against the latched length.
- Reports per-requester done/error pulses and enforces an inter-packet gap.

---
 rtl/udp_tx_arbiter.sv | 149 ++++++++++++++
 tb/tb_udp_tx_arbiter.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_tx_arbiter.sv
// Round-robin arbiter sharing the UDP transmit path among
// NUM_REQ packet sources, with ack timeout and inter-packet gap.
module udp_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ACK_TIMEOUT = 50000,
  parameter int GAP_CYCLES  = 8
) (
  input  logic                   clk_50,
  input  logic                   sys_rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [16*NUM_REQ-1:0]  req_length,
  input  logic [8*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]     req_grant,
  output logic [NUM_REQ-1:0]     req_data_rd,
  output logic [NUM_REQ-1:0]     req_done,
  output logic [NUM_REQ-1:0]     req_err,
  input  logic                   udp_tx_ready,
  input  logic                   app_tx_ack,
  output logic                   app_tx_data_request,
  output logic                   app_tx_data_valid,
  output logic [7:0]             app_tx_data,
  output logic [15:0]            udp_data_length,
  output logic                   busy
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

  typedef enum logic [2:0] {
    IDLE, WAIT_RDY, REQ, STREAM, WAIT_END, GAP
  } state_t;

  state_t        state;
  logic [IW-1:0] g;
  logic [IW-1:0] ptr;
  logic [IW-1:0] sel;
  logic          found;
  logic [15:0]   cnt;
  logic [TW-1:0] tmo;
  logic [GW-1:0] gap;
  logic [15:0]   len_a [NUM_REQ];
  logic [7:0]    dat_a [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign len_a[i] = req_length[16*i +: 16];
    assign dat_a[i] = req_data[8*i +: 8];
  end

  // Search starts just past the last winner, so it ranks last.
  always_comb begin
    int j;
    j     = 0;
    sel   = ptr;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!found && req_valid[IW'(j)]) begin
        sel   = IW'(j);
        found = 1'b1;
      end
    end
  end

  assign req_data_rd = (state == STREAM) ? (ONE << g) : '0;
  assign busy        = (state != IDLE);

  always_ff @(posedge clk_50) begin
    if (!sys_rst_n) begin
      state               <= IDLE;
      g                   <= '0;
      ptr                 <= IW'(NUM_REQ - 1);
      req_grant           <= '0;
      req_done            <= '0;
      req_err             <= '0;
      app_tx_data_request <= 1'b0;
      app_tx_data_valid   <= 1'b0;
      app_tx_data         <= '0;
      udp_data_length     <= '0;
      cnt                 <= '0;
      tmo                 <= '0;
      gap                 <= '0;
    end else begin
      req_done          <= '0;
      req_err           <= '0;
      app_tx_data_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (found) begin
            g               <= sel;
            ptr             <= sel;
            req_grant       <= ONE << sel;
            udp_data_length <= len_a[sel];
            cnt             <= len_a[sel];
            state           <= WAIT_RDY;
          end
        end
        WAIT_RDY: begin
          if (cnt == 16'd0) begin
            req_err   <= ONE << g;
            req_grant <= '0;
            gap       <= GW'(GAP_CYCLES - 1);
            state     <= GAP;
          end else if (udp_tx_ready) begin
            app_tx_data_request <= 1'b1;
            tmo                 <= '0;
            state               <= REQ;
          end
        end
        REQ: begin
          tmo <= tmo + 1'b1;
          if (app_tx_ack) begin
            app_tx_data_request <= 1'b0;
            state               <= STREAM;
          end else if (tmo == TW'(ACK_TIMEOUT - 1)) begin
            app_tx_data_request <= 1'b0;
            req_err             <= ONE << g;
            req_grant           <= '0;
            gap                 <= GW'(GAP_CYCLES - 1);
            state               <= GAP;
          end
        end
        STREAM: begin
          cnt               <= cnt - 16'd1;
          app_tx_data       <= dat_a[g];
          app_tx_data_valid <= 1'b1;
          if (cnt == 16'd1) state <= WAIT_END;
        end
        WAIT_END: begin
          // Last byte is still on the bus during the first cycle here.
          if (!app_tx_data_valid && udp_tx_ready) begin
            req_done  <= ONE << g;
            req_grant <= '0;
            gap       <= GW'(GAP_CYCLES - 1);
            state     <= GAP;
          end
        end
        GAP: begin
          if (gap == '0) state <= IDLE;
          else           gap   <= gap - 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// Directed bench for udp_tx_arbiter: handshake, round-robin,
// zero length, ack timeout, ready stalls and mid-packet reset.
module tb_udp_tx_arbiter;

  localparam int N  = 4;
  localparam int AT = 20;
  localparam int GC = 8;

  logic            clk_50 = 1'b0;
  logic            sys_rst_n;
  logic [N-1:0]    req_valid;
  logic [16*N-1:0] req_length;
  logic [8*N-1:0]  req_data;
  logic [N-1:0]    req_grant;
  logic [N-1:0]    req_data_rd;
  logic [N-1:0]    req_done;
  logic [N-1:0]    req_err;
  logic            udp_tx_ready;
  logic            app_tx_ack;
  logic            app_tx_data_request;
  logic            app_tx_data_valid;
  logic [7:0]      app_tx_data;
  logic [15:0]     udp_data_length;
  logic            busy;

  udp_tx_arbiter #(
    .NUM_REQ     (N),
    .ACK_TIMEOUT (AT),
    .GAP_CYCLES  (GC)
  ) dut (
    .clk_50              (clk_50),
    .sys_rst_n           (sys_rst_n),
    .req_valid           (req_valid),
    .req_length          (req_length),
    .req_data            (req_data),
    .req_grant           (req_grant),
    .req_data_rd         (req_data_rd),
    .req_done            (req_done),
    .req_err             (req_err),
    .udp_tx_ready        (udp_tx_ready),
    .app_tx_ack          (app_tx_ack),
    .app_tx_data_request (app_tx_data_request),
    .app_tx_data_valid   (app_tx_data_valid),
    .app_tx_data         (app_tx_data),
    .udp_data_length     (udp_data_length),
    .busy                (busy)
  );

  always #10 clk_50 = ~clk_50;

  // FWFT requester model: byte k of source i is base[i]+k+1
  logic [7:0] base [N];
  logic [7:0] pos  [N];
  logic       pos_clr;

  always @(posedge clk_50) begin
    for (int i = 0; i < N; i++) begin
      if (pos_clr)             pos[i] <= 8'd0;
      else if (req_data_rd[i]) pos[i] <= pos[i] + 8'd1;
    end
  end

  always_comb begin
    req_data = '0;
    for (int i = 0; i < N; i++)
      req_data[8*i +: 8] = base[i] + pos[i] + 8'd1;
  end

  function automatic int oh2i(input logic [N-1:0] v);
    for (int i = 0; i < N; i++)
      if (v[i]) return i;
    return -1;
  endfunction

  logic [7:0]   byte_q [$];
  int           grant_q [$];
  int           run_q [$];
  int           run_len = 0;
  int           req_hi  = 0;
  logic [N-1:0] pg      = '0;

  always @(negedge clk_50) begin
    if (app_tx_data_valid) begin
      byte_q.push_back(app_tx_data);
      run_len <= run_len + 1;
    end else if (run_len != 0) begin
      run_q.push_back(run_len);
      run_len <= 0;
    end
    if (app_tx_data_request) req_hi <= req_hi + 1;
    if (req_grant != '0 && pg == '0)
      grant_q.push_back(oh2i(req_grant));
    pg <= req_grant;
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk_50);
    #1;
  endtask

  task automatic set_len(input int i, input logic [15:0] v);
    req_length[16*i +: 16] = v;
  endtask

  task automatic clr_pos;
    pos_clr = 1'b1;
    tick;
    pos_clr = 1'b0;
  endtask

  task automatic do_reset;
    sys_rst_n = 1'b0;
    tick;
    sys_rst_n = 1'b1;
  endtask

  task automatic run_pkt(input  logic auto_ack,
                         output int   who,
                         output logic was_err);
    who     = -1;
    was_err = 1'b0;
    for (int c = 0; c < 400; c++) begin
      tick;
      if (auto_ack) app_tx_ack = app_tx_data_request;
      if ((req_done | req_err) != '0) begin
        who        = oh2i(req_done | req_err);
        was_err    = |req_err;
        app_tx_ack = 1'b0;
        return;
      end
    end
  endtask

  task automatic wait_idle;
    for (int c = 0; c < 40; c++) begin
      if (!busy) break;
      tick;
    end
    chk("idle", busy, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          who, c, n, b0, g0, r0;
    logic        e;
    logic [N-1:0] d;
    int          ord [5];

    sys_rst_n    = 1'b0;
    req_valid    = '0;
    req_length   = '0;
    udp_tx_ready = 1'b1;
    app_tx_ack   = 1'b0;
    pos_clr      = 1'b1;
    base[0] = 8'hA0; base[1] = 8'hB0;
    base[2] = 8'hC0; base[3] = 8'hD0;
    repeat (3) tick;
    chk("rst_strobes",
        {req_grant, req_data_rd, req_done, req_err}, 0);
    chk("rst_tx",
        {app_tx_data_request, app_tx_data_valid, app_tx_data}, 0);
    chk("rst_len", udp_data_length, 0);
    chk("rst_busy", busy, 0);
    pos_clr   = 1'b0;
    sys_rst_n = 1'b1;
    tick;

    // single packet, ack two cycles after request
    set_len(0, 16'd3);
    req_valid = 4'b0001;
    b0 = byte_q.size();
    tick;
    chk("t1_grant", req_grant, 4'b0001);
    chk("t1_len", udp_data_length, 3);
    tick;
    chk("t1_req", app_tx_data_request, 1);
    tick;
    app_tx_ack = 1'b1;
    tick;
    app_tx_ack = 1'b0;
    run_pkt(1'b0, who, e);
    req_valid = '0;
    chk("t1_who", who, 0);
    chk("t1_done", req_done, 4'b0001);
    chk("t1_grant_drop", req_grant, 0);
    chk("t1_nbytes", byte_q.size() - b0, 3);
    if (byte_q.size() >= b0 + 3) begin
      chk("t1_b0", byte_q[b0], 8'hA1);
      chk("t1_b1", byte_q[b0+1], 8'hA2);
      chk("t1_b2", byte_q[b0+2], 8'hA3);
    end
    chk("t1_run", run_q[$], 3);
    for (c = 1; c <= 20; c++) begin
      tick;
      if (!busy) break;
    end
    chk("t1_gap", c, GC);

    // two requesters, then all four held for five packets
    do_reset;
    clr_pos;
    set_len(0, 16'd1);
    set_len(2, 16'd1);
    req_valid = 4'b0101;
    g0 = grant_q.size();
    b0 = byte_q.size();
    run_pkt(1'b1, who, e);
    req_valid[0] = 1'b0;
    chk("t2_first", who, 0);
    run_pkt(1'b1, who, e);
    req_valid[2] = 1'b0;
    chk("t2_second", who, 2);
    chk("t2_byte", byte_q[$], 8'hC1);
    chk("t2_nbytes", byte_q.size() - b0, 2);
    wait_idle;

    do_reset;
    for (int i = 0; i < N; i++) set_len(i, 16'd1);
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      run_pkt(1'b1, who, e);
      ord[k] = who;
    end
    req_valid = '0;
    chk("rr_0", ord[0], 0);
    chk("rr_1", ord[1], 1);
    chk("rr_2", ord[2], 2);
    chk("rr_3", ord[3], 3);
    chk("rr_4", ord[4], 0);
    wait_idle;

    // zero length on req1, req3 follows after the gap
    clr_pos;
    set_len(1, 16'd0);
    set_len(3, 16'd2);
    r0 = req_hi;
    req_valid = 4'b1010;
    tick;
    chk("t3_grant", req_grant, 4'b0010);
    tick;
    chk("t3_err", req_err, 4'b0010);
    chk("t3_drop", req_grant, 0);
    chk("t3_noreq", req_hi - r0, 0);
    req_valid[1] = 1'b0;
    for (c = 1; c <= 20; c++) begin
      tick;
      if (req_grant != '0) break;
    end
    chk("t3_gap", c, GC + 1);
    chk("t3_next", req_grant, 4'b1000);
    run_pkt(1'b1, who, e);
    req_valid = '0;
    chk("t3_who", who, 3);
    chk("t3_run", run_q[$], 2);
    chk("t3_byte", byte_q[$], 8'hD2);
    wait_idle;

    // ack timeout, then ack on the final allowed cycle
    clr_pos;
    set_len(2, 16'd2);
    r0 = req_hi;
    b0 = byte_q.size();
    req_valid = 4'b0100;
    run_pkt(1'b0, who, e);
    chk("t4_who", who, 2);
    chk("t4_err", e, 1);
    chk("t4_reqcyc", req_hi - r0, AT);
    chk("t4_nobytes", byte_q.size() - b0, 0);
    r0 = req_hi;
    n  = 0;
    for (int k = 0; k < 100; k++) begin
      tick;
      if (app_tx_data_request) n++;
      if (n == AT) begin
        app_tx_ack = 1'b1;
        tick;
        app_tx_ack = 1'b0;
        break;
      end
    end
    run_pkt(1'b0, who, e);
    req_valid = '0;
    chk("t4b_who", who, 2);
    chk("t4b_err", e, 0);
    chk("t4b_reqcyc", req_hi - r0, AT);
    chk("t4b_run", run_q[$], 2);
    chk("t4b_byte", byte_q[$], 8'hC2);
    wait_idle;

    // ready low for 10 cycles before request and before done
    clr_pos;
    set_len(3, 16'd2);
    udp_tx_ready = 1'b0;
    req_valid    = 4'b1000;
    tick;
    chk("t5_grant", req_grant, 4'b1000);
    n = 0;
    repeat (10) begin
      tick;
      if (app_tx_data_request) n++;
    end
    chk("t5_noreq", n, 0);
    udp_tx_ready = 1'b1;
    tick;
    chk("t5_req", app_tx_data_request, 1);
    app_tx_ack = 1'b1;
    tick;
    app_tx_ack   = 1'b0;
    udp_tx_ready = 1'b0;
    e = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick;
      if (e && !app_tx_data_valid) break;
      if (app_tx_data_valid) e = 1'b1;
    end
    d = '0;
    repeat (10) begin
      tick;
      d = d | req_done;
    end
    chk("t5_nodone", d, 0);
    udp_tx_ready = 1'b1;
    tick;
    chk("t5_done", req_done, 4'b1000);
    req_valid = '0;
    wait_idle;

    // reset during byte 2 of 5
    clr_pos;
    set_len(0, 16'd5);
    set_len(1, 16'd1);
    req_valid = 4'b0001;
    n = 0;
    for (int k = 0; k < 100; k++) begin
      tick;
      app_tx_ack = app_tx_data_request;
      if (app_tx_data_valid) n++;
      if (n == 2) break;
    end
    chk("t6_midbyte", app_tx_data, 8'h52 - 8'h50 + 8'hA0);
    sys_rst_n  = 1'b0;
    app_tx_ack = 1'b0;
    req_valid  = 4'b0011;
    tick;
    chk("t6_strobes",
        {req_grant, req_data_rd, req_done, req_err}, 0);
    chk("t6_tx",
        {app_tx_data_request, app_tx_data_valid, app_tx_data}, 0);
    chk("t6_len", udp_data_length, 0);
    chk("t6_busy", busy, 0);
    sys_rst_n = 1'b1;
    g0 = grant_q.size();
    run_pkt(1'b1, who, e);
    req_valid[0] = 1'b0;
    chk("t6_first", who, 0);
    chk("t6_glog", grant_q[g0], 0);
    run_pkt(1'b1, who, e);
    req_valid = '0;
    chk("t6_second", who, 1);
    wait_idle;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
